// File: rtl/serial_framer_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_framer_mc_if : FIFO read side and serial output bundle of the framer |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface serial_framer_mc_if #(
  parameter int LANES = 1
);
  logic             req;
  logic [LANES-1:0] datain;
  logic             pop;
  logic [LANES-1:0] dataout;
  logic             dvalid;
  logic             abort;
  logic [2:0]       state;

  modport master (
    input  req, datain,
    output pop, dataout, dvalid, abort, state
  );

  modport slave (
    output req, datain,
    input  pop, dataout, dvalid, abort, state
  );
endinterface
`default_nettype wire

// File: rtl/serial_framer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_framer_mc : multi-lane lockstep serial framer fed by an FWFT FIFO    |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module serial_framer_mc #(
  parameter int                 LANES       = 1,
  parameter int                 PAYLOAD_LEN = 32,
  parameter int                 DELIM_W     = 8,
  parameter logic [DELIM_W-1:0] SOF         = 'h5A,
  parameter logic [DELIM_W-1:0] EOF         = 'h0F,
  parameter bit                 PARITY_EN   = 1'b1,
  parameter int                 GAP_CYCLES  = 2,
  parameter int                 STALL_MAX   = 16
) (
  input  logic               s_clk,
  input  logic               rst_n,
  serial_framer_mc_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_EOF  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam int c_DCW = (DELIM_W > 1) ? $clog2(DELIM_W) : 1;
  localparam int c_BCW = $clog2(PAYLOAD_LEN + 1);
  localparam int c_SCW = $clog2(STALL_MAX + 1);
  localparam int c_GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [c_DCW-1:0] c_DLAST = c_DCW'(DELIM_W - 1);
  localparam logic [c_BCW-1:0] c_BFULL = c_BCW'(PAYLOAD_LEN);
  localparam logic [c_SCW-1:0] c_SLAST = c_SCW'(STALL_MAX - 1);
  localparam logic [c_GCW-1:0] c_GLAST = c_GCW'(GAP_CYCLES - 1);

  state_t             r_state;
  logic [c_DCW-1:0]   r_dcnt;
  logic [c_BCW-1:0]   r_bcnt;
  logic [c_SCW-1:0]   r_scnt;
  logic [c_GCW-1:0]   r_gcnt;
  logic [DELIM_W-1:0] r_delim;
  logic [LANES-1:0]   r_parity;
  logic [LANES-1:0]   r_dataout;
  logic               r_dvalid;
  logic               r_abort;

  logic w_last_sof;
  logic w_beats_left;
  logic w_take;
  logic w_pop;
  logic w_timeout;

  // The last SOF cycle prefetches beat 0 so payload follows the delimiter with no bubble.
  assign w_last_sof   = (r_state == ST_SOF) && (r_dcnt == c_DLAST);
  assign w_beats_left = (r_bcnt != c_BFULL);
  assign w_take       = w_last_sof || (r_state == ST_DATA);
  assign w_pop        = bus.req && w_beats_left && w_take;
  assign w_timeout    = !bus.req && w_beats_left && w_take && (r_scnt == c_SLAST);

  assign bus.pop     = w_pop;
  assign bus.dataout = r_dataout;
  assign bus.dvalid  = r_dvalid;
  assign bus.abort   = r_abort;
  assign bus.state   = r_state;

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dcnt    <= '0;
      r_bcnt    <= '0;
      r_scnt    <= '0;
      r_gcnt    <= '0;
      r_delim   <= '0;
      r_parity  <= '0;
      r_dataout <= '0;
      r_dvalid  <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dataout <= '0;
          r_dvalid  <= 1'b0;
          if (bus.req) begin
            r_state   <= ST_SOF;
            r_dcnt    <= '0;
            r_delim   <= SOF << 1;
            r_dataout <= {LANES{SOF[DELIM_W-1]}};
            r_dvalid  <= 1'b1;
            r_bcnt    <= '0;
            r_scnt    <= '0;
            r_parity  <= '0;
          end
        end

        ST_SOF, ST_DATA: begin
          if ((r_state == ST_SOF) && !w_last_sof) begin
            r_dcnt    <= r_dcnt + c_DCW'(1);
            r_dataout <= {LANES{r_delim[DELIM_W-1]}};
            r_delim   <= r_delim << 1;
            r_dvalid  <= 1'b1;
          end else if (!w_beats_left) begin
            if (PARITY_EN) begin
              r_state   <= ST_PAR;
              r_dataout <= r_parity;
              r_dvalid  <= 1'b1;
            end else begin
              r_state   <= ST_EOF;
              r_dcnt    <= '0;
              r_delim   <= EOF << 1;
              r_dataout <= {LANES{EOF[DELIM_W-1]}};
              r_dvalid  <= 1'b1;
            end
          end else begin
            r_state <= ST_DATA;
            if (w_pop) begin
              r_dataout <= bus.datain;
              r_dvalid  <= 1'b1;
              r_bcnt    <= r_bcnt + c_BCW'(1);
              r_scnt    <= '0;
              r_parity  <= r_parity ^ bus.datain;
            end else if (w_timeout) begin
              // Abandon the payload: parity is skipped, EOF still closes the frame.
              r_abort   <= 1'b1;
              r_scnt    <= '0;
              r_state   <= ST_EOF;
              r_dcnt    <= '0;
              r_delim   <= EOF << 1;
              r_dataout <= {LANES{EOF[DELIM_W-1]}};
              r_dvalid  <= 1'b1;
            end else begin
              r_dvalid <= 1'b0;
              r_scnt   <= r_scnt + c_SCW'(1);
            end
          end
        end

        ST_PAR: begin
          r_state   <= ST_EOF;
          r_dcnt    <= '0;
          r_delim   <= EOF << 1;
          r_dataout <= {LANES{EOF[DELIM_W-1]}};
          r_dvalid  <= 1'b1;
        end

        ST_EOF: begin
          if (r_dcnt == c_DLAST) begin
            r_state   <= ST_GAP;
            r_gcnt    <= '0;
            r_dataout <= '0;
            r_dvalid  <= 1'b0;
          end else begin
            r_dcnt    <= r_dcnt + c_DCW'(1);
            r_dataout <= {LANES{r_delim[DELIM_W-1]}};
            r_delim   <= r_delim << 1;
            r_dvalid  <= 1'b1;
          end
        end

        ST_GAP: begin
          r_dataout <= '0;
          r_dvalid  <= 1'b0;
          if (r_gcnt == c_GLAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gcnt <= r_gcnt + c_GCW'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_dataout <= '0;
          r_dvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
